// File: rtl/vc_arbiter_ctrl_pkg.sv
// Shared types for the virtual-channel arbiter controller.
package vc_arbiter_ctrl_pkg;
   localparam int NSRC = 4;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;
endpackage

// File: rtl/vc_arbiter_ctrl_if.sv
// Source/destination FIFO bundle between the arbiter controller and its FIFOs.
interface vc_arbiter_ctrl_if #(
   parameter int BW   = 6,
   parameter int LEN4 = 4
);
   import vc_arbiter_ctrl_pkg::*;

   logic                 init;
   logic [LEN4-1:0]      umbral_low_in;
   logic [LEN4-1:0]      umbral_high_in;
   logic [NSRC-1:0]      src_empty;
   logic [NSRC-1:0]      src_almost_full;
   logic [NSRC*BW-1:0]   src_data;
   logic                 dst_full;
   logic                 dst_almost_full;
   logic [LEN4-1:0]      umbral_low;
   logic [LEN4-1:0]      umbral_high;
   logic [NSRC-1:0]      src_rd;
   logic                 dst_wr;
   logic [BW-1:0]        dst_data;
   logic                 idle;
   logic                 error;

   modport master (
      input  init, umbral_low_in, umbral_high_in, src_empty, src_almost_full,
             src_data, dst_full, dst_almost_full,
      output umbral_low, umbral_high, src_rd, dst_wr, dst_data, idle, error
   );

   modport slave (
      output init, umbral_low_in, umbral_high_in, src_empty, src_almost_full,
             src_data, dst_full, dst_almost_full,
      input  umbral_low, umbral_high, src_rd, dst_wr, dst_data, idle, error
   );
endinterface

// File: rtl/vc_arbiter_ctrl_rr_pick.sv
// Combinational 4-way picker: lowest urgent index wins, else round-robin from ptr.
module rr_pick
   import vc_arbiter_ctrl_pkg::*;
(
   input  logic [NSRC-1:0] req,
   input  logic [NSRC-1:0] urgent,
   input  logic [1:0]      ptr,
   output logic            gnt_valid,
   output logic [1:0]      gnt_idx
);
   logic [1:0] cand;

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = '0;
      cand      = '0;
      if (|urgent) begin
         for (int i = NSRC - 1; i >= 0; i--) begin
            if (urgent[i]) gnt_idx = 2'(i);
         end
      end else begin
         // walk backwards so the closest candidate to ptr is written last
         for (int k = NSRC - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) gnt_idx = cand;
         end
      end
   end
endmodule

// File: rtl/vc_arbiter_ctrl.sv
// Shares one destination FIFO among four source VC FIFOs; owns thresholds and
// the INIT/IDLE/ACTIVE life cycle, popping at most one word per cycle.
//
// state     | meaning
// ST_INIT   | thresholds follow *_in every cycle, no pops
// ST_IDLE   | all sources drained, nothing in flight
// ST_ACTIVE | arbitrating and popping one word per cycle
module vc_arbiter_ctrl
   import vc_arbiter_ctrl_pkg::*;
#(
   parameter int BW           = 6,
   parameter int LEN4         = 4,
   parameter int UMB_LOW_RST  = 1,
   parameter int UMB_HIGH_RST = 3
) (
   input logic              clk,
   input logic              reset_L,
   vc_arbiter_ctrl_if.master bus
);
   state_t          state, state_nx;
   logic [1:0]      rr_ptr;
   logic [NSRC-1:0] req;
   logic            gnt_valid;
   logic [1:0]      gnt_idx;
   logic            pop_en;
   logic            in_flight;

   logic            v_q, v_q2;
   logic [1:0]      sel_q, sel_q2;
   logic [NSRC-1:0] rd_q;
   logic            wr_q;
   logic [BW-1:0]   data_q;
   logic [LEN4-1:0] low_q, high_q;
   logic            err_q;

   assign req       = ~bus.src_empty;
   assign in_flight = v_q | v_q2;

   rr_pick u_pick (
      .req       (req),
      .urgent    (bus.src_almost_full & req),
      .ptr       (rr_ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      state_nx = state;
      pop_en   = 1'b0;
      case (state)
         ST_INIT: begin
            if (!bus.init) state_nx = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.init)  state_nx = ST_INIT;
            else if (|req) state_nx = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (bus.init) begin
               state_nx = ST_INIT;
            end else begin
               pop_en = gnt_valid && !bus.dst_almost_full;
               if (!(|req) && !in_flight) state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_INIT;
      endcase
   end

   // grant -> src_rd (sel_q) -> source data valid (sel_q2) -> dst_wr
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state  <= ST_INIT;
         rr_ptr <= '0;
         rd_q   <= '0;
         v_q    <= 1'b0;
         sel_q  <= '0;
         v_q2   <= 1'b0;
         sel_q2 <= '0;
         wr_q   <= 1'b0;
         data_q <= '0;
         low_q  <= LEN4'(UMB_LOW_RST);
         high_q <= LEN4'(UMB_HIGH_RST);
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         rd_q   <= pop_en ? (NSRC'(1) << gnt_idx) : '0;
         v_q    <= pop_en;
         if (pop_en) begin
            sel_q  <= gnt_idx;
            rr_ptr <= gnt_idx + 2'd1;
         end
         v_q2   <= v_q;
         sel_q2 <= sel_q;
         wr_q   <= v_q2;
         if (v_q2) data_q <= bus.src_data[int'(sel_q2) * BW +: BW];
         if (state == ST_INIT) begin
            low_q  <= bus.umbral_low_in;
            high_q <= bus.umbral_high_in;
         end
         if (wr_q && bus.dst_full) err_q <= 1'b1;
      end
   end

   assign bus.src_rd      = rd_q;
   assign bus.dst_wr      = wr_q;
   assign bus.dst_data    = data_q;
   assign bus.umbral_low  = low_q;
   assign bus.umbral_high = high_q;
   assign bus.idle        = (state == ST_IDLE);
   assign bus.error       = err_q;
endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// Bench for vc_arbiter_ctrl: queue-based source FIFOs plus a time-stamped
// behavioural model compared against the DUT every cycle.
module tb_vc_arbiter_ctrl;
   localparam int BW   = 6;
   localparam int LEN4 = 4;

   logic clk = 1'b0;
   logic reset_L;

   vc_arbiter_ctrl_if #(.BW(BW), .LEN4(LEN4)) bus ();

   vc_arbiter_ctrl #(
      .BW(BW), .LEN4(LEN4), .UMB_LOW_RST(1), .UMB_HIGH_RST(3)
   ) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // stimulus knobs
   logic            k_init, k_dst_af, k_dst_full;
   logic [3:0]      k_af;
   logic [LEN4-1:0] k_low, k_high;

   // source FIFOs as the DUT sees them
   logic [BW-1:0] srcq [4][$];
   logic [BW-1:0] dout [4];
   logic [3:0]    last_rd;

   // model: unclaimed words per source, expectations keyed by cycle
   logic [BW-1:0]   mq [4][$];
   int              m_mode;   // 0 init, 1 idle, 2 active
   int              m_ptr;
   logic            m_err;
   logic [LEN4-1:0] m_low, m_high;
   logic [BW-1:0]   m_data;
   logic [3:0]      e_rd [int];
   logic [BW-1:0]   e_data [int];

   logic [3:0]      obs_rd;
   logic            obs_wr, obs_idle, obs_err;
   logic [BW-1:0]   obs_data;
   logic [LEN4-1:0] obs_low, obs_high;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [BW-1:0] w);
      srcq[i].push_back(w);
      mq[i].push_back(w);
   endtask

   function automatic int pick();
      for (int i = 0; i < 4; i++)
         if (mq[i].size() > 0 && k_af[i]) return i;
      for (int k = 0; k < 4; k++)
         if (mq[(m_ptr + k) % 4].size() > 0) return (m_ptr + k) % 4;
      return 0;
   endfunction

   task automatic model_step();
      int   nxt;
      int   g;
      bit   any;
      bit   infl;
      logic err_n;
      nxt  = m_mode;
      any  = 1'b0;
      for (int i = 0; i < 4; i++) if (mq[i].size() > 0) any = 1'b1;
      infl  = e_rd.exists(cyc) || e_data.exists(cyc + 1);
      err_n = m_err | (e_data.exists(cyc) && k_dst_full);
      if (m_mode == 0) begin
         m_low  = k_low;
         m_high = k_high;
      end
      case (m_mode)
         0: if (!k_init) nxt = 1;
         1: begin
            if (k_init) nxt = 0;
            else if (any) nxt = 2;
         end
         default: begin
            if (k_init) nxt = 0;
            else begin
               if (!k_dst_af && any) begin
                  g = pick();
                  e_rd[cyc + 1]   = 4'(1 << g);
                  e_data[cyc + 3] = mq[g].pop_front();
                  m_ptr = (g + 1) % 4;
               end
               if (!any && !infl) nxt = 1;
            end
         end
      endcase
      m_mode = nxt;
      m_err  = err_n;
   endtask

   task automatic drive_and_step();
      logic [3:0] emp;
      for (int i = 0; i < 4; i++)
         if (last_rd[i] && srcq[i].size() > 0) dout[i] = srcq[i].pop_front();
      last_rd = bus.src_rd;
      // source flags empty once the pop under way would drain it
      for (int i = 0; i < 4; i++) emp[i] = (srcq[i].size() <= int'(last_rd[i]));
      bus.src_empty       = emp;
      bus.src_data        = {dout[3], dout[2], dout[1], dout[0]};
      bus.src_almost_full = k_af;
      bus.init            = k_init;
      bus.umbral_low_in   = k_low;
      bus.umbral_high_in  = k_high;
      bus.dst_almost_full = k_dst_af;
      bus.dst_full        = k_dst_full;
      model_step();
   endtask

   task automatic check_cycle();
      obs_rd   = bus.src_rd;
      obs_wr   = bus.dst_wr;
      obs_data = bus.dst_data;
      obs_idle = bus.idle;
      obs_err  = bus.error;
      obs_low  = bus.umbral_low;
      obs_high = bus.umbral_high;
      if (e_data.exists(cyc)) m_data = e_data[cyc];
      chk("src_rd", 32'(obs_rd), e_rd.exists(cyc) ? 32'(e_rd[cyc]) : 32'd0);
      chk("dst_wr", 32'(obs_wr), 32'(e_data.exists(cyc)));
      chk("dst_data", 32'(obs_data), 32'(m_data));
      chk("idle", 32'(obs_idle), 32'(m_mode == 1));
      chk("error", 32'(obs_err), 32'(m_err));
      chk("umbral_low", 32'(obs_low), 32'(m_low));
      chk("umbral_high", 32'(obs_high), 32'(m_high));
   endtask

   task automatic cycle();
      @(negedge clk);
      check_cycle();
      drive_and_step();
      cyc++;
   endtask

   task automatic do_reset();
      #2 reset_L = 1'b0;
      #1;
      chk("rst_src_rd", 32'(bus.src_rd), 32'd0);
      chk("rst_dst_wr", 32'(bus.dst_wr), 32'd0);
      chk("rst_dst_data", 32'(bus.dst_data), 32'd0);
      chk("rst_idle", 32'(bus.idle), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_low", 32'(bus.umbral_low), 32'd1);
      chk("rst_high", 32'(bus.umbral_high), 32'd3);
      m_mode = 0; m_ptr = 0; m_err = 1'b0; m_low = 4'd1; m_high = 4'd3; m_data = '0;
      e_rd.delete();
      e_data.delete();
      for (int i = 0; i < 4; i++) begin
         srcq[i].delete();
         mq[i].delete();
         dout[i] = '0;
      end
      last_rd = '0;
      @(negedge clk);
      #1 reset_L = 1'b1;
      drive_and_step();
      cyc++;
   endtask

   logic [BW-1:0] got [$];
   logic [3:0]    rds [$];
   logic [BW-1:0] rr_exp [8];
   int first_t, last_t, wr_cnt, total;

   initial begin
      reset_L = 1'b1;
      k_init = 1'b1; k_low = 4'd2; k_high = 4'd5;
      k_af = '0; k_dst_af = 1'b0; k_dst_full = 1'b0;
      last_rd = '0;
      do_reset();

      // configuration
      repeat (3) cycle();
      k_init = 1'b0;
      repeat (2) cycle();
      chk("cfg_low", 32'(obs_low), 32'd2);
      chk("cfg_high", 32'(obs_high), 32'd5);
      chk("cfg_idle", 32'(obs_idle), 32'd1);

      // round-robin across four sources
      rr_exp = '{6'h01, 6'h11, 6'h21, 6'h31, 6'h02, 6'h12, 6'h22, 6'h32};
      for (int i = 0; i < 4; i++) begin
         push(i, 6'(16 * i + 1));
         push(i, 6'(16 * i + 2));
      end
      got.delete(); first_t = -1; last_t = -1;
      for (int t = 0; t < 16; t++) begin
         cycle();
         if (obs_wr) begin
            got.push_back(obs_data);
            if (first_t < 0) first_t = t;
            last_t = t;
         end
      end
      chk("rr_count", 32'(got.size()), 32'd8);
      for (int k = 0; k < got.size() && k < 8; k++) chk("rr_order", 32'(got[k]), 32'(rr_exp[k]));
      chk("rr_span", 32'(last_t - first_t), 32'd7);
      chk("rr_idle", 32'(obs_idle), 32'd1);

      // almost-full override with rr_ptr at 1
      push(0, 6'h05);
      repeat (8) cycle();
      k_af = 4'b1000;
      push(1, 6'h15);
      push(3, 6'h35);
      rds.delete();
      for (int t = 0; t < 10; t++) begin
         cycle();
         if (obs_rd != 0) rds.push_back(obs_rd);
      end
      k_af = '0;
      chk("ovr_count", 32'(rds.size()), 32'd2);
      if (rds.size() >= 2) begin
         chk("ovr_first", 32'(rds[0]), 32'b1000);
         chk("ovr_second", 32'(rds[1]), 32'b0010);
      end

      // back-pressure for 5 cycles mid-stream
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 3; k++) push(i, 6'(16 * i + 4 + k));
      wr_cnt = 0; total = 0;
      for (int t = 0; t < 25; t++) begin
         if (t == 6)  k_dst_af = 1'b1;
         if (t == 11) k_dst_af = 1'b0;
         cycle();
         if (t >= 7 && t <= 11) begin
            chk("bp_rd_zero", 32'(obs_rd), 32'd0);
            if (obs_wr) wr_cnt++;
         end
         if (t == 12) chk("bp_resume", 32'(obs_rd != 0), 32'd1);
         if (obs_wr) total++;
      end
      chk("bp_wr_le2", 32'(wr_cnt <= 2), 32'd1);
      chk("bp_total", 32'(total), 32'd12);

      // sticky error
      chk("err_before", 32'(obs_err), 32'd0);
      k_dst_full = 1'b1;
      push(2, 6'h2A);
      repeat (8) cycle();
      k_dst_full = 1'b0;
      repeat (4) cycle();
      chk("err_sticky", 32'(obs_err), 32'd1);
      do_reset();

      // async reset mid-burst
      repeat (2) cycle();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) push(i, 6'(16 * i + 8 + k));
      repeat (6) cycle();
      chk("burst_wr", 32'(obs_wr), 32'd1);
      do_reset();

      // randomized traffic
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 99) < 45) push($urandom_range(0, 3), 6'($urandom));
         k_af       = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
         k_dst_af   = ($urandom_range(0, 9) < 2);
         k_dst_full = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 199) == 0) k_init = 1'b1;
         else if (k_init && $urandom_range(0, 3) == 0) k_init = 1'b0;
         k_low  = 4'($urandom);
         k_high = 4'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vc_arbiter_ctrl.md
# vc_arbiter_ctrl

Controller and arbiter that shares one downstream FIFO among four source virtual-channel FIFOs (D0..D3, each a `fifo_cond` instance with programmable low/high thresholds). It owns the threshold configuration for all four sources, sequences the INIT → IDLE → ACTIVE life cycle, and pops at most one word per cycle into the destination FIFO. Arbitration is round-robin with an almost-full override, and the block stalls on downstream back-pressure.

## Interface
Parameters:
- `BW`, 6, data width of every FIFO word
- `LEN4`, 4, threshold width (matches source FIFO depth encoding)
- `UMB_LOW_RST`, 1, reset value of `umbral_low`
- `UMB_HIGH_RST`, 3, reset value of `umbral_high`

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `reset_L`  in  1  asynchronous, active-low reset
- `init`  in  1  1 = configuration mode; thresholds load every cycle
- `umbral_low_in`  in  LEN4  low threshold to apply to all sources
- `umbral_high_in`  in  LEN4  high threshold to apply to all sources
- `src_empty`  in  4  per-source empty flags
- `src_almost_full`  in  4  per-source almost-full flags
- `src_data`  in  4*BW  packed source read data; source i occupies bits [i*BW +: BW]
- `dst_full`  in  1  destination full flag
- `dst_almost_full`  in  1  destination almost-full flag (stall)
- `umbral_low`  out  LEN4  registered low threshold, driven to all sources
- `umbral_high`  out  LEN4  registered high threshold, driven to all sources
- `src_rd`  out  4  one-hot or zero pop strobe, registered
- `dst_wr`  out  1  destination write strobe, registered
- `dst_data`  out  BW  destination write data, registered
- `idle`  out  1  high when state is IDLE
- `error`  out  1  sticky: a write was issued while `dst_full` was 1

## Operation
- **States:** INIT, IDLE, ACTIVE. Reset state is INIT.
- **INIT**
  - `umbral_low` and `umbral_high` are loaded from the `*_in` inputs every cycle.
  - No pops are issued.
  - On `init`=0, go to IDLE.
- **IDLE**
  - If any `src_empty` bit is 0 and `init`=0, go to ACTIVE.
  - `init`=1 goes to INIT.
- **ACTIVE**
  - A pop is issued in a cycle when all of the following hold: `init`=0, `dst_almost_full`=0, and at least one source is non-empty.
  - Go to IDLE when all sources are empty and no word is in flight.
  - `init`=1 goes to INIT immediately. Pops stop in that same cycle; in-flight words still complete their write.
- **Selection** among non-empty sources:
  - If any non-empty source has `src_almost_full`=1, the lowest such index wins.
  - Otherwise, round-robin: search starts at `rr_ptr`, wrapping 3→0.
  - After every grant, `rr_ptr` = granted index + 1 mod 4. An override grant updates `rr_ptr` the same way.
- **Data path**
  - The granted index is registered as `sel_q` alongside a valid bit.
  - On the following cycle, `src_data[sel_q]` is captured into `dst_data` and `dst_wr` is asserted.
- **Back-pressure**
  - `dst_almost_full` must guarantee at least 2 free destination entries, which covers the two in-flight words.
  - `dst_full`=1 during a `dst_wr` cycle sets `error`. The write still pulses and the word is lost.
  - `error` clears only on reset.

## Timing
- **Reset values:** `src_rd`=0, `dst_wr`=0, `dst_data`=0, `umbral_low`=UMB_LOW_RST, `umbral_high`=UMB_HIGH_RST, `idle`=0, `error`=0, `rr_ptr`=0, state INIT.
- **Pop latency:** a grant decided in cycle N drives `src_rd` high in N+1. The source presents data in N+2, and `dst_wr`/`dst_data` are valid in N+3.
- **Sustained rate:** one word per cycle with back-to-back pops.
- **Pipeline depth:** at most 2 words are in flight.
- **Stall:** `dst_almost_full` rising in cycle N suppresses the grant decided in N. Words already granted still complete.
- **Threshold update:** a change on `umbral_*_in` during INIT appears on `umbral_*` one cycle later. Outside INIT, the thresholds hold.
- **Reset mid-operation:** all outputs return to reset values asynchronously and in-flight words are discarded.

## Structure
- **Shared package:** state encoding (INIT=0, IDLE=1, ACTIVE=2, 2-bit) and source count NSRC=4.
- **One sub-module, `rr_pick`:** combinational 4-way picker.
  - Inputs: `req[3:0]`, `urgent[3:0]`, `ptr[1:0]`.
  - Outputs: `gnt_valid`, `gnt_idx[1:0]`.
- **Top level:** FSM, grant register, data capture, and threshold registers.

## Test plan
- **Config:** reset, `init`=1 with low=2/high=5 for 3 cycles, then `init`=0 → `umbral_low`=2, `umbral_high`=5, state IDLE, `idle`=1.
- **Round-robin:** preload sources 0..3 with 2 words each (0x01/0x02, 0x11/0x12, 0x21/0x22, 0x31/0x32), no almost-full → `dst_data` order 01,11,21,31,02,12,22,32, one per cycle; `idle`=1 after drain.
- **Override:** sources 1 and 3 non-empty, `rr_ptr`=1, `src_almost_full[3]`=1 → `src_rd`=4'b1000 first, then source 1.
- **Back-pressure:** `dst_almost_full`=1 for 5 cycles mid-stream → `src_rd` stays 0 within 1 cycle, at most 2 `dst_wr` after assertion, resumes 1 cycle after release with no word lost or duplicated.
- **Error:** force `dst_full`=1 while a word is in flight → `error`=1 and it stays 1 until `reset_L`=0.
- **Async reset:** drop `reset_L` mid-burst → `src_rd`, `dst_wr`, `dst_data` = 0 immediately and state INIT.
